// File: rtl/adder_seg_pkg.sv
// -----------------------------------------------------------------------------
// adder_seg_pkg
// Shared constants, types and helpers for the segmented 64-bit adder.
//   WIDTH         : operand width (64)
//   SEG_W_DEFAULT : default segment width processed per cycle
//   state_e       : controller states IDLE / RUN / DONE
//   num_seg()     : number of segments for a given segment width
//   idx_width()   : width of the segment index counter (never below 1 bit)
// -----------------------------------------------------------------------------
package adder_seg_pkg;

  localparam int WIDTH         = 64;
  localparam int SEG_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int num_seg(input int seg_w);
    return WIDTH / seg_w;
  endfunction

  // A single-segment build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_seg_slice.sv
// -----------------------------------------------------------------------------
// adder_seg_slice
// Purely combinational SEG_W-bit ripple adder built from per-bit
// generate/propagate terms.
// Ports:
//   a_i, b_i  : SEG_W-bit operand segments
//   cin_i     : carry into bit 0 of the segment
//   sum_o     : SEG_W-bit segment sum
//   cout_o    : carry out of the segment MSB
// -----------------------------------------------------------------------------
module adder_seg_slice #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o
);

  logic [SEG_W-1:0] gen;
  logic [SEG_W-1:0] prop;
  logic [SEG_W:0]   carry;

  assign gen      = a_i & b_i;
  assign prop     = a_i ^ b_i;
  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < SEG_W; gi++) begin : g_ripple
    assign carry[gi+1] = gen[gi] | (prop[gi] & carry[gi]);
  end

  assign sum_o  = prop ^ carry[SEG_W-1:0];
  assign cout_o = carry[SEG_W];

endmodule

// File: rtl/adder_seg_64u.sv
// -----------------------------------------------------------------------------
// adder_seg_64u
// Unsigned 64-bit adder that processes SEG_W bits per clock, least
// significant segment first, with valid/ready handshakes on both sides.
// Operands are captured on accept, so a/b may change while the add runs.
// Latency from the accepting edge to out_valid is 64/SEG_W cycles; a new
// operand pair may be accepted in the same cycle the previous result retires.
//
// Optional feature: define ADDER_SEG_CIN_EN to add a carry-in port (cin),
// sampled together with a and b. Without it the carry-in is 0.
//
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset (discards any operation)
//   cin        : carry-in (only with ADDER_SEG_CIN_EN)
//   in_valid   : a/b valid         in_ready  : operands accepted this cycle
//   a, b       : 64-bit operands
//   out_valid  : sum/cout valid    out_ready : consumer takes result
//   sum        : a+b(+cin) mod 2^64
//   cout       : carry out of bit 63
// -----------------------------------------------------------------------------
module adder_seg_64u
  import adder_seg_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ADDER_SEG_CIN_EN
  input  logic             cin,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NUM_SEG = num_seg(SEG_W);
  localparam int IDX_W   = idx_width(NUM_SEG);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic             cout_q;

  logic             accept;
  logic             carry_in;
  logic             last_seg;
  logic [SEG_W-1:0] seg_a;
  logic [SEG_W-1:0] seg_b;
  logic [SEG_W-1:0] seg_sum;
  logic             seg_cout;

`ifdef ADDER_SEG_CIN_EN
  assign carry_in = cin;
`else
  assign carry_in = 1'b0;
`endif

  // Ready in IDLE, or in DONE when the current result is being taken.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign last_seg  = (idx_q == IDX_W'(NUM_SEG - 1));

  // Segment selection from the captured operands.
  if (NUM_SEG == 1) begin : g_single
    assign seg_a = a_q;
    assign seg_b = b_q;
  end else begin : g_multi
    logic [SEG_W-1:0] a_seg [NUM_SEG];
    logic [SEG_W-1:0] b_seg [NUM_SEG];
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      assign a_seg[gi] = a_q[gi*SEG_W +: SEG_W];
      assign b_seg[gi] = b_q[gi*SEG_W +: SEG_W];
    end
    assign seg_a = a_seg[idx_q];
    assign seg_b = b_seg[idx_q];
  end

  adder_seg_slice #(
    .SEG_W (SEG_W)
  ) u_slice (
    .a_i    (seg_a),
    .b_i    (seg_b),
    .cin_i  (carry_q),
    .sum_o  (seg_sum),
    .cout_o (seg_cout)
  );

  // Result register with the current segment replaced.
  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sum_d[i*SEG_W +: SEG_W] = seg_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            carry_q <= carry_in;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= seg_cout;
          idx_q   <= idx_q + 1'b1;
          if (last_seg) begin
            cout_q  <= seg_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              // Retire and restart in the same cycle.
              a_q     <= a;
              b_q     <= b;
              idx_q   <= '0;
              carry_q <= carry_in;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seg_64u.sv
// -----------------------------------------------------------------------------
// tb_adder_seg_64u
// Directed-vector bench for adder_seg_64u (default SEG_W=16). The driver
// pushes the hand-computed result into a queue at accept; an independent
// monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_adder_seg_64u;

  logic        clk = 1'b0;
  logic        rst;
  logic        cin_s;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;

  always #5 clk = ~clk;

  adder_seg_64u dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ADDER_SEG_CIN_EN
    .cin       (cin_s),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, record the expected result.
  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                      input logic [63:0] es, input logic ec, input bit lat,
                      output int acc);
    int n;
    a = av; b = bv; cin_s = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    acc = cyc;
    if (!in_ready) begin
      check("accept_timeout", {64'b0, in_ready}, 65'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      acc = cyc;
      sb.push_back('{es, ec, acc, lat});
      in_valid = 1'b0;
      // Operand changes while running must not leak into the result.
      a = ~av; b = ~bv; cin_s = ~ci;
      $display("issue a=%h b=%h cin=%0d expect sum=%h cout=%0d at cycle %0d", av, bv, ci, es, ec, acc);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() > 0) check("drain_timeout", 65'(sb.size()), 65'd0);
  endtask

  // Monitor: compare every retired result against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {64'b0, out_valid}, 65'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result sum=%h cout=%0d expect sum=%h cout=%0d at cycle %0d", sum, cout, e.sum, e.cout, cyc);
        check("sum", {1'b0, sum}, {1'b0, e.sum});
        check("cout", {64'b0, cout}, {64'b0, e.cout});
        check("in_ready_done", {64'b0, in_ready}, 65'd1);
        if (e.chk_lat) check("latency", 65'(cyc - e.acc), 65'd4);
      end
    end
  end

  localparam int NV = 5;
  logic [63:0] tv_a [NV];
  logic [63:0] tv_b [NV];
  logic [63:0] tv_s [NV];
  logic        tv_c [NV];

  initial begin
    int acc1;
    int acc2;
    int n;

    tv_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; tv_b[0] = 64'h1;
    tv_s[0] = 64'h0;                   tv_c[0] = 1'b1;
    tv_a[1] = 64'h0000_0000_0000_FFFF; tv_b[1] = 64'h1;
    tv_s[1] = 64'h0000_0000_0001_0000; tv_c[1] = 1'b0;
    tv_a[2] = 64'h0;                   tv_b[2] = 64'h0;
    tv_s[2] = 64'h0;                   tv_c[2] = 1'b0;
    tv_a[3] = 64'hAAAA_AAAA_AAAA_AAAA; tv_b[3] = 64'h5555_5555_5555_5555;
    tv_s[3] = 64'hFFFF_FFFF_FFFF_FFFF; tv_c[3] = 1'b0;
    tv_a[4] = 64'hFFFF_FFFF_FFFF_FFFF; tv_b[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    tv_s[4] = 64'hFFFF_FFFF_FFFF_FFFE; tv_c[4] = 1'b1;

    // Reset dominates simultaneous in_valid and out_ready.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; cin_s = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1;
    repeat (3) tick();
    check("rst_out_valid", {64'b0, out_valid}, 65'd0);
    check("rst_in_ready", {64'b0, in_ready}, 65'd1);
    check("rst_sum", {1'b0, sum}, 65'd0);
    check("rst_cout", {64'b0, cout}, 65'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Directed table, consumer always ready.
    for (int i = 0; i < NV; i++) begin
      send(tv_a[i], tv_b[i], 1'b0, tv_s[i], tv_c[i], 1'b1, acc1);
      wait_drain();
    end

    // Consumer stalls for 10 cycles: result must hold.
    out_ready = 1'b0;
    send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
         64'h2222_2222_2222_2211, 1'b0, 1'b0, acc1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("stall_latency", 65'(cyc - acc1), 65'd4);
    for (int i = 0; i < 10; i++) begin
      check("stall_out_valid", {64'b0, out_valid}, 65'd1);
      check("stall_sum", {1'b0, sum}, {1'b0, 64'h2222_2222_2222_2211});
      check("stall_cout", {64'b0, cout}, 65'd0);
      check("stall_in_ready", {64'b0, in_ready}, 65'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain();
    tick();

    // Reset in the second RUN cycle discards the operation.
    a = 64'h1; b = 64'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_out_valid", {64'b0, out_valid}, 65'd0);
    check("midrun_rst_in_ready", {64'b0, in_ready}, 65'd1);
    check("midrun_rst_sum", {1'b0, sum}, 65'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrun_no_output", {64'b0, out_valid}, 65'd0);
      tick();
    end
    send(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b1, acc1);
    wait_drain();

    // Back-to-back: second op accepted in the retire cycle.
    send(64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b1, acc1);
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
         64'h0, 1'b1, 1'b1, acc2);
    check("b2b_spacing", 65'(acc2 - acc1), 65'd5);
    wait_drain();

    // Carry-in behaviour depends on the build.
`ifdef ADDER_SEG_CIN_EN
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b1, acc1);
`else
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, acc1);
`endif
    wait_drain();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
